// File: rtl/fetch_queue.sv
// fetch_queue: sequential ibus fetch (one outstanding request) into a DEPTH-entry queue; FETCH_QUEUE_BYPASS_EN adds empty-queue bypass.
// Latency: data_ok to out_valid 1 cycle (0 cycles through the bypass when enabled).
// Backpressure: out_ready low fills the queue; a full queue only stalls request issue.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          ILEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [63:0]     redirect_pc,
  output logic            ireq_valid,
  output logic [63:0]     ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [ILEN-1:0] iresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            out_error,
  output logic            empty,
  output logic            full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic NOERROR = 1'b0;
  localparam logic INSTR_MISALIGN = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HALT} state_t;

  state_t          state, state_nxt;
  logic [63:0]     fetch_pc, fetch_pc_nxt;
  logic [63:0]     req_addr;
  logic [AW-1:0]   head, tail;
  logic [AW:0]     count;
  logic [63:0]     pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic            err_mem   [DEPTH];
  logic            enq, deq, bypass;
  logic [ILEN-1:0] enq_instr;
  logic            enq_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (state == IDLE && state_nxt == BUSY)
        req_addr <= fetch_pc;
    end
  end

  // A redirect always retargets fetch_pc; an in-flight request must still finish on the bus.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = redirect ? redirect_pc : fetch_pc;
    case (state)
      IDLE: begin
        if (!redirect) begin
          if (fetch_pc[1:0] != 2'b00) begin
            if (!full) state_nxt = HALT;
          end else if (count < FULL_CNT) begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (iresp_data_ok) begin
          state_nxt = IDLE;
          if (!redirect) fetch_pc_nxt = fetch_pc + 64'd4;
        end else if (redirect) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN:   if (iresp_data_ok) state_nxt = IDLE;
      HALT:    if (redirect) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enq       = 1'b0;
    bypass    = 1'b0;
    enq_instr = iresp_data;
    enq_err   = NOERROR;
    case (state)
      IDLE: begin
        if (!redirect && fetch_pc[1:0] != 2'b00 && !full) begin
          enq       = 1'b1;
          enq_instr = '0;
          enq_err   = INSTR_MISALIGN;
        end
      end
      BUSY: begin
        if (iresp_data_ok && !redirect) begin
`ifdef FETCH_QUEUE_BYPASS_EN
          bypass = (count == '0) && out_ready;
`endif
          enq = !bypass;
        end
      end
      default: ;
    endcase
  end

  assign ireq_valid = (state == BUSY) || (state == DRAIN);
  assign ireq_addr  = req_addr;
  assign deq        = (count != '0) && out_ready;
  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign out_valid  = (count != '0) || bypass;
  assign out_pc     = (count != '0) ? pc_mem[head]    : (bypass ? fetch_pc   : '0);
  assign out_instr  = (count != '0) ? instr_mem[head] : (bypass ? iresp_data : '0);
  assign out_error  = (count != '0) ? err_mem[head]   : NOERROR;

  // Flush wins over any same-cycle enqueue or dequeue.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= enq_instr;
      err_mem[tail]   <= enq_err;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based behavioural model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_error;
  logic        empty, full;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .ILEN(32)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_error(out_error), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] at(input logic [63:0] qq[$], input int i);
    return (i < qq.size()) ? qq[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // Bus responder: answers each request after lat cycles (lat<0 picks 0..3 at random).
  int lat = 1;
  int wcnt = -1;
  always begin
    @(posedge clk); #1;
    iresp_data_ok = 1'b0;
    if (ireq_valid) begin
      if (wcnt < 0) wcnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      if (wcnt == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data    = $urandom;
        wcnt          = -1;
      end else begin
        wcnt--;
      end
    end else begin
      wcnt = -1;
    end
  end

  bit rand_on = 0;
  int ready_pct = 100;
  always begin
    @(posedge clk); #2;
    if (rand_on) begin
      out_ready   = ($urandom_range(0, 99) < ready_pct);
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = RPC + 64'($urandom_range(0, 255)) * 64'd4
                    + (($urandom_range(0, 4) == 0) ? 64'd2 : 64'd0);
      reset       = ($urandom_range(0, 499) == 0);
    end
  end

  // Reference model: the queue contents plus whether a request is outstanding and whether it is stale.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;
  ent_t        q[$];
  logic [63:0] m_pc = RPC;
  logic [63:0] m_req_addr = '0;
  bit          m_out = 0, m_stale = 0, m_halt = 0;
  bit          started = 0;
  bit          bus_busy = 0;
  logic [63:0] iss_log[$];
  logic [63:0] acc_pc[$];
  logic [63:0] acc_err[$];

  always begin
    @(negedge clk);
    begin
      automatic bit byp = 0;
      automatic int sz = q.size();
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = m_out && !m_stale && iresp_data_ok && !redirect && sz == 0 && out_ready;
`endif
      if (started && !reset) begin
        check("out_valid", 64'(out_valid), 64'(sz > 0 || byp));
        check("empty", 64'(empty), 64'(sz == 0));
        check("full", 64'(full), 64'(sz == DEPTH));
        check("ireq_valid", 64'(ireq_valid), 64'(m_out));
        if (m_out) check("ireq_addr", ireq_addr, m_req_addr);
        if (sz > 0) begin
          check("out_pc", out_pc, q[0].pc);
          check("out_instr", 64'(out_instr), 64'(q[0].instr));
          check("out_error", 64'(out_error), 64'(q[0].err));
        end else if (byp) begin
          check("byp_pc", out_pc, m_req_addr);
          check("byp_instr", 64'(out_instr), 64'(iresp_data));
          check("byp_error", 64'(out_error), 64'd0);
        end
        if (ireq_valid && !bus_busy) begin
          iss_log.push_back(ireq_addr);
          bus_busy = 1;
        end
        if (!ireq_valid || iresp_data_ok) bus_busy = 0;
        if (out_valid && out_ready) begin
          acc_pc.push_back(out_pc);
          acc_err.push_back(64'(out_error));
        end
      end
      if (reset) begin
        q.delete();
        m_pc = RPC; m_out = 0; m_stale = 0; m_halt = 0; bus_busy = 0;
      end else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (redirect) begin
          q.delete();
          m_pc   = redirect_pc;
          m_halt = 0;
          if (m_out) begin
            if (iresp_data_ok) begin m_out = 0; m_stale = 0; end
            else m_stale = 1;
          end
        end else if (m_out) begin
          if (iresp_data_ok) begin
            if (!m_stale) begin
              if (!byp) q.push_back('{m_req_addr, iresp_data, 1'b0});
              m_pc = m_pc + 64'd4;
            end
            m_out = 0; m_stale = 0;
          end
        end else if (!m_halt && sz < DEPTH) begin
          if (m_pc[1:0] == 2'b00) begin
            m_out = 1; m_req_addr = m_pc;
          end else begin
            q.push_back('{m_pc, 32'd0, 1'b1});
            m_halt = 1;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    #1;
    iss_log.delete(); acc_pc.delete(); acc_err.delete();
  endtask

  task automatic pulse_redirect(input logic [63:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    @(posedge clk); #2 redirect = 1'b0;
  endtask

  int n;
  bit ok;
  int chunk_ready[8] = '{100, 30, 70, 0, 90, 50, 100, 10};

  initial begin
    out_ready = 1'b1;
    lat = 1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    started = 1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_error", 64'(out_error), 64'd0);

    // Streaming with a one-cycle bus.
    repeat (20) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      check("seq_ireq_addr", at(iss_log, i), RPC + 64'(4 * i));
      check("seq_out_pc", at(acc_pc, i), RPC + 64'(4 * i));
      check("seq_out_err", at(acc_err, i), 64'd0);
    end

    // Stalled decode fills the queue, then drains in order.
    out_ready = 1'b0;
    do_reset();
    repeat (30) @(posedge clk);
    #3;
    check("stall_full", 64'(full), 64'd1);
    check("stall_ireq_valid", 64'(ireq_valid), 64'd0);
    check("stall_issued", 64'(iss_log.size()), 64'd4);
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    for (int i = 0; i < 4; i++) check("drain_pc", at(acc_pc, i), RPC + 64'(4 * i));
    check("resume_addr", at(iss_log, 4), RPC + 64'h10);

    // Redirect while the request to +8 waits three cycles on the bus.
    lat = 3;
    do_reset();
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #3;
      ok = ireq_valid && ireq_addr == RPC + 64'h8;
    end
    check("wait_req8", 64'(ok), 64'd1);
    pulse_redirect(64'h8000_1000);
    repeat (25) @(posedge clk);
    check("redir_held_req", at(iss_log, 2), RPC + 64'h8);
    check("redir_next_req", at(iss_log, 3), 64'h8000_1000);
    check("redir_first_out", at(acc_pc, 2), 64'h8000_1000);

    // Misaligned target produces one error entry and stops fetch.
    #1 pulse_redirect(64'h8000_0002);
    n = iss_log.size();
    repeat (15) @(posedge clk);
    check("mis_no_issue", 64'(iss_log.size()), 64'(n));
    check("mis_pc", at(acc_pc, acc_pc.size() - 1), 64'h8000_0002);
    check("mis_err", at(acc_err, acc_err.size() - 1), 64'd1);
    #1 pulse_redirect(64'h8000_0100);
    repeat (10) @(posedge clk);
    check("mis_resume", at(iss_log, n), 64'h8000_0100);

    // Redirect coinciding with data_ok.
    lat = 2;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #3;
      ok = ireq_valid && iresp_data_ok;
    end
    check("wait_dataok", 64'(ok), 64'd1);
    pulse_redirect(64'h8000_2000);
    n = iss_log.size();
    repeat (10) @(posedge clk);
    check("same_cycle_next", at(iss_log, n), 64'h8000_2000);

    // Reset while full.
    out_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #3;
      ok = full;
    end
    check("wait_full", 64'(ok), 64'd1);
    do_reset();
    check("rstfull_empty", 64'(empty), 64'd1);
    check("rstfull_out_valid", 64'(out_valid), 64'd0);
    repeat (5) @(posedge clk);
    check("rstfull_first_req", at(iss_log, 0), RPC);

`ifdef FETCH_QUEUE_BYPASS_EN
    out_ready = 1'b1;
    lat = 1;
    do_reset();
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #3;
      ok = iresp_data_ok;
    end
    check("byp_seen", 64'(ok), 64'd1);
    check("byp_out_valid", 64'(out_valid), 64'd1);
    check("byp_out_instr", 64'(out_instr), 64'(iresp_data));
    check("byp_empty", 64'(empty), 64'd1);
`endif

    // Random traffic against the model.
    lat = -1;
    rand_on = 1;
    foreach (chunk_ready[i]) begin
      ready_pct = chunk_ready[i];
      repeat (500) @(posedge clk);
    end
    rand_on = 0;
    @(posedge clk); #2;
    reset = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
